mem_slave: RTL



---
 rtl/mem_pkg.sv | 17 +
 rtl/mem_parity_ram.sv | 46 ++++
 rtl/mem_slave.sv | 153 +++++++++++++++
 3 files changed

// File: rtl/mem_pkg.sv
// Shared definitions for the lab memory responder.
// Holds the default geometry, the FSM state type and the error-counter ceiling.
package mem_pkg;

  // Default geometry: 32 words of 8 data bits, plus one parity bit per word.
  localparam int DEF_ADDR_W = 5;
  localparam int DEF_DATA_W = 8;

  // The parity error counter stops here instead of wrapping.
  localparam logic [7:0] ERR_CNT_MAX = 8'd255;

  typedef enum logic {
    INIT = 1'b0,
    IDLE = 1'b1
  } mem_state_t;

endpackage : mem_pkg

// File: rtl/mem_parity_ram.sv
// Single-port storage array for the memory responder.
// The array has no reset. The read register does have an async reset, so the
// read data comes out of reset as all zeros. That register holds its value
// until the next enabled read.
// Ports:
//   clk, rst_n - clock and async active-low reset (read register only)
//   we, re     - write enable and read enable (never both high from mem_slave)
//   addr       - shared word address
//   wdata      - word to store (parity bit in the MSB)
//   rdata      - registered read word
module mem_parity_ram #(
  parameter int ADDR_W = 5,
  parameter int WORD_W = 9
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              we,
  input  logic              re,
  input  logic [ADDR_W-1:0] addr,
  input  logic [WORD_W-1:0] wdata,
  output logic [WORD_W-1:0] rdata
);

  localparam int DEPTH = 2 ** ADDR_W;

  logic [WORD_W-1:0] mem [DEPTH];

  // Synchronous write into the array.
  always_ff @(posedge clk) begin
    if (we) begin
      mem[addr] <= wdata;
    end
  end

  // Registered read port; holds its value between accepted reads.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rdata <= '0;
    end else if (re) begin
      rdata <= mem[addr];
    end else begin
      rdata <= rdata;
    end
  end

endmodule : mem_parity_ram

// File: rtl/mem_slave.sv
// Lab memory bus responder. It is a 32x8 memory with even parity on each word
// and a one-cycle registered read. After reset it runs a clear sweep that
// writes zero to every location, and it holds busy high while the sweep runs.
// Ports:
//   clk, rst_n          - clock, async active-low reset
//   addr, data_in       - request address and write data
//   read, write         - request strobes; both together is a protocol error
//   inj_par             - inverts the stored parity bit of a write (test hook)
//   data_out, rd_valid  - read data and its one-cycle valid strobe
//   par_err             - parity failure on the word now shown on data_out
//   err_cnt             - saturating parity error count. It updates on the edge
//                         after the par_err strobe.
//   proto_err           - sticky, set by simultaneous read and write
//   busy                - clear sweep in progress; requests ignored
module mem_slave
  import mem_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int DATA_W = DEF_DATA_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] data_in,
  input  logic              read,
  input  logic              write,
  input  logic              inj_par,
  output logic [DATA_W-1:0] data_out,
  output logic              rd_valid,
  output logic              par_err,
  output logic [7:0]        err_cnt,
  output logic              proto_err,
  output logic              busy
);

  localparam int DEPTH = 2 ** ADDR_W;
  // The sweep ends when ptr reaches the last address, not when it wraps.
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

  // Even parity bit for a data word.
  function automatic logic parity_of(input logic [DATA_W-1:0] d);
    return ^d;
  endfunction

  // A stored word is consistent when the XOR over all its bits is zero.
  function automatic logic word_bad(input logic [DATA_W:0] w);
    return ^w;
  endfunction

  mem_state_t        state;
  logic [ADDR_W-1:0] ptr;
  logic              ram_we;
  logic              ram_re;
  logic [ADDR_W-1:0] ram_addr;
  logic [DATA_W:0]   ram_wdata;
  logic [DATA_W:0]   ram_rdata;

  mem_parity_ram #(
    .ADDR_W (ADDR_W),
    .WORD_W (DATA_W + 1)
  ) u_ram (
    .clk   (clk),
    .rst_n (rst_n),
    .we    (ram_we),
    .re    (ram_re),
    .addr  (ram_addr),
    .wdata (ram_wdata),
    .rdata (ram_rdata)
  );

  // Request decode. During the sweep the array port belongs to ptr.
  always_comb begin
    ram_we    = 1'b0;
    ram_re    = 1'b0;
    ram_addr  = addr;
    ram_wdata = '0;
    case (state)
      INIT: begin
        ram_we    = 1'b1;
        ram_addr  = ptr;
        ram_wdata = '0;
      end
      IDLE: begin
        ram_we    = write & ~read;
        ram_re    = read & ~write;
        ram_addr  = addr;
        ram_wdata = {parity_of(data_in) ^ inj_par, data_in};
      end
      default: begin
        ram_we    = 1'b0;
        ram_re    = 1'b0;
        ram_addr  = addr;
        ram_wdata = '0;
      end
    endcase
  end

  // Control FSM: sweep pointer, busy, read strobe and sticky protocol flag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= INIT;
      ptr       <= '0;
      busy      <= 1'b1;
      rd_valid  <= 1'b0;
      proto_err <= 1'b0;
    end else begin
      case (state)
        INIT: begin
          rd_valid <= 1'b0;
          ptr      <= ptr + 1'b1;
          if (ptr == LAST_ADDR) begin
            state <= IDLE;
            busy  <= 1'b0;
          end else begin
            state <= INIT;
            busy  <= 1'b1;
          end
        end
        IDLE: begin
          rd_valid <= read & ~write;
          if (read && write) begin
            proto_err <= 1'b1;
          end else begin
            proto_err <= proto_err;
          end
        end
        default: begin
          state    <= INIT;
          ptr      <= '0;
          busy     <= 1'b1;
          rd_valid <= 1'b0;
        end
      endcase
    end
  end

  // Parity error counter. It counts each par_err strobe and stops at the ceiling.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_cnt <= 8'd0;
    end else if (par_err && (err_cnt != ERR_CNT_MAX)) begin
      err_cnt <= err_cnt + 8'd1;
    end else begin
      err_cnt <= err_cnt;
    end
  end

  // Data is passed through uncorrected. The parity flag is qualified by the
  // strobe, so it only shows up alongside a fresh read word.
  assign data_out = ram_rdata[DATA_W-1:0];
  assign par_err  = rd_valid & word_bad(ram_rdata);

endmodule : mem_slave
